// File: rtl/uart_bus_bridge.sv
// Bus master that polls the UART register port, feeding SEND from a transmit
// stream and draining RECV into a small RX FIFO with a valid/ready output.
module uart_bus_bridge #(
  parameter int RX_DEPTH   = 4,
  parameter int TX_HOLDOFF = 8
) (
  input  logic                      clk_bus,
  input  logic                      rst,
  input  logic                      enable,
  output logic [3:0]                bus_address,
  output logic                      bus_read,
  output logic                      bus_write,
  output logic [31:0]               bus_wdata,
  input  logic [31:0]               bus_rdata,
  input  logic [7:0]                tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [7:0]                rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [$clog2(RX_DEPTH):0] rx_count
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(TX_HOLDOFF + 2);

  localparam logic [3:0] ADDR_RECV   = 4'h4;
  localparam logic [3:0] ADDR_SEND   = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  typedef enum logic [1:0] {IDLE, POLL, RD_RX, WR_TX} state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   holdoff;
  logic            last_rx;
  logic [7:0]      mem [RX_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            rx_ok, tx_ok, push, pop;
  logic            unused_rdata;

  assign unused_rdata = ^bus_rdata[31:8];

  assign rx_ok = bus_rdata[1] && (rx_count < CW'(RX_DEPTH));
  assign tx_ok = bus_rdata[0] && (holdoff == '0) && tx_valid;

  // When both sides are eligible, serve whichever was not served last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = POLL;
      POLL: begin
        if (rx_ok && (!tx_ok || !last_rx)) state_nxt = RD_RX;
        else if (tx_ok)                    state_nxt = WR_TX;
        else if (!enable)                  state_nxt = IDLE;
      end
      RD_RX,
      WR_TX:   state_nxt = enable ? POLL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_address = '0;
    bus_read    = 1'b0;
    bus_write   = 1'b0;
    bus_wdata   = '0;
    tx_ready    = 1'b0;
    case (state)
      POLL: begin
        bus_read    = 1'b1;
        bus_address = ADDR_STATUS;
      end
      RD_RX: begin
        bus_read    = 1'b1;
        bus_address = ADDR_RECV;
      end
      WR_TX: begin
        bus_write   = 1'b1;
        bus_address = ADDR_SEND;
        bus_wdata   = {24'b0, tx_data};
        tx_ready    = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      holdoff <= '0;
      last_rx <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == WR_TX)      holdoff <= HW'(TX_HOLDOFF);
      else if (holdoff != '0)  holdoff <= holdoff - 1'b1;
      if (state == RD_RX)      last_rx <= 1'b1;
      else if (state == WR_TX) last_rx <= 1'b0;
    end
  end

  assign push     = (state == RD_RX);
  assign pop      = rx_valid && rx_ready;
  assign rx_valid = (rx_count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  // NOTE: the storage array is not reset; rx_data is masked while empty instead.
  always_ff @(posedge clk_bus) begin
    if (push) mem[wr_ptr] <= bus_rdata[7:0];
  end

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge with a behavioural UART register model.
module tb_uart_bus_bridge;

  logic        clk_bus = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  bus_address;
  logic        bus_read, bus_write;
  logic [31:0] bus_wdata, bus_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [2:0]  rx_count;

  uart_bus_bridge #(.RX_DEPTH(4), .TX_HOLDOFF(8)) dut (
    .clk_bus(clk_bus), .rst(rst), .enable(enable),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_count(rx_count)
  );

  always #5 clk_bus = ~clk_bus;

  // UART model: offer[] is filled by the stimulus, lb[] by SEND writes in loopback.
  logic [7:0] offer [64];
  int         offer_n = 0;
  int         offer_rd = 0;
  logic [7:0] lb [64];
  int         lb_n = 0;
  int         lb_rd = 0;
  logic       tx_idle = 1'b0;
  logic       loopback = 1'b0;

  wire       src_avail = loopback ? (lb_rd < lb_n) : (offer_rd < offer_n);
  wire [7:0] src_head  = loopback ? lb[lb_rd] : offer[offer_rd];

  assign bus_rdata = !bus_read              ? 32'h0 :
                     (bus_address == 4'hC)  ? {30'h0, src_avail, tx_idle} :
                     (bus_address == 4'h4)  ? {24'hDEADBE, src_head} : 32'h0;

  always @(posedge clk_bus) begin
    logic       rd_now, wr_now;
    logic [7:0] wd;
    rd_now = bus_read && (bus_address == 4'h4) && !rst;
    wr_now = bus_write && (bus_address == 4'h8) && !rst;
    wd     = bus_wdata[7:0];
    #1;
    if (rd_now) begin
      if (loopback) lb_rd = lb_rd + 1;
      else          offer_rd = offer_rd + 1;
    end
    if (wr_now && loopback) begin
      lb[lb_n] = wd;
      lb_n     = lb_n + 1;
    end
  end

  // Monitor: logs accesses, writes and FIFO pops at the falling edge.
  logic [7:0] acc[$];
  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  logic       wr_rdy[$];
  logic [7:0] pops[$];
  int         cyc = 0;
  int         proto_bad = 0;

  always @(negedge clk_bus) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (bus_read && bus_address == 4'h4) acc.push_back(8'h52);
      if (bus_write) begin
        acc.push_back(8'h57);
        wr_data.push_back(bus_wdata[7:0]);
        wr_cyc.push_back(cyc);
        wr_rdy.push_back(tx_ready);
      end
      if (tx_ready != bus_write) proto_bad = proto_bad + 1;
      if (rx_valid && rx_ready) pops.push_back(rx_data);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_bus);
    #1;
  endtask

  task automatic offer_byte(input logic [7:0] b);
    offer[offer_n] = b;
    offer_n = offer_n + 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic got;
    got      = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_bus);
      if (tx_ready) got = 1'b1;
    end
    @(posedge clk_bus);
    #1;
    tx_valid = 1'b0;
    check("tx_handshake", {31'b0, got}, 32'h1);
  endtask

  logic [7:0] tx_vec [4] = '{8'hAA, 8'h00, 8'h55, 8'hFF};
  logic [7:0] rx_vec [4] = '{8'h01, 8'h80, 8'h92, 8'hA7};
  logic [7:0] bp_vec [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  function automatic int count_reads(input int from);
    int n = 0;
    for (int i = from; i < acc.size(); i++) if (acc[i] == 8'h52) n++;
    return n;
  endfunction

  initial begin
    int ab, pb, wb;
    logic got;
    rst = 1'b1; enable = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    #1;
    check("rst_read",    {31'b0, bus_read},  32'h0);
    check("rst_write",   {31'b0, bus_write}, 32'h0);
    check("rst_addr",    {28'b0, bus_address}, 32'h0);
    check("rst_wdata",   bus_wdata, 32'h0);
    check("rst_txready", {31'b0, tx_ready},  32'h0);
    check("rst_rxvalid", {31'b0, rx_valid},  32'h0);
    check("rst_rxcount", {29'b0, rx_count},  32'h0);
    check("rst_rxdata",  {24'b0, rx_data},   32'h0);
    cycles(2);
    rst = 1'b0;

    // TX path
    tx_idle = 1'b1;
    wb = wr_data.size();
    ab = acc.size();
    for (int i = 0; i < 4; i++) send_byte(tx_vec[i]);
    cycles(4);
    check("tx_count", wr_data.size() - wb, 4);
    for (int i = 0; i < 4; i++) begin
      check("tx_data", {24'b0, wr_data[wb+i]}, {24'b0, tx_vec[i]});
      check("tx_ready_on_write", {31'b0, wr_rdy[wb+i]}, 32'h1);
      if (i > 0) check("tx_gap", {31'b0, (wr_cyc[wb+i] - wr_cyc[wb+i-1]) >= 10}, 32'h1);
    end
    check("tx_no_recv", count_reads(ab), 0);

    // RX path
    rx_ready = 1'b1;
    pb = pops.size();
    ab = acc.size();
    for (int i = 0; i < 4; i++) offer_byte(rx_vec[i]);
    cycles(30);
    check("rx_reads", count_reads(ab), 4);
    check("rx_pops", pops.size() - pb, 4);
    for (int i = 0; i < 4; i++) check("rx_data", {24'b0, pops[pb+i]}, {24'b0, rx_vec[i]});

    // RX backpressure
    rx_ready = 1'b0;
    pb = pops.size();
    ab = acc.size();
    for (int i = 0; i < 6; i++) offer_byte(bp_vec[i]);
    cycles(40);
    check("bp_count_full", {29'b0, rx_count}, 32'h4);
    check("bp_reads_stop", count_reads(ab), 4);
    check("bp_head", {24'b0, rx_data}, 32'h11);
    rx_ready = 1'b1;
    cycles(40);
    check("bp_reads_all", count_reads(ab), 6);
    check("bp_pops", pops.size() - pb, 6);
    for (int i = 0; i < 6; i++) check("bp_data", {24'b0, pops[pb+i]}, {24'b0, bp_vec[i]});
    check("bp_count_empty", {29'b0, rx_count}, 32'h0);

    // Contention: restart from reset so arbitration starts RX-preferred
    rst = 1'b1;
    cycles(1);
    for (int i = 0; i < 8; i++) offer_byte(8'hC0 + 8'(i));
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    ab = acc.size();
    wb = wr_data.size();
    rst = 1'b0;
    cycles(30);
    tx_valid = 1'b0;
    check("arb_first_rx",  {24'b0, acc[ab]},   32'h52);
    check("arb_second_tx", {24'b0, acc[ab+1]}, 32'h57);
    check("arb_third_rx",  {24'b0, acc[ab+2]}, 32'h52);
    check("arb_tx_twice", {31'b0, (wr_data.size() - wb) >= 2}, 32'h1);
    check("arb_tx_gap", {31'b0, (wr_cyc[wb+1] - wr_cyc[wb]) >= 10}, 32'h1);
    cycles(30);

    // Loopback
    loopback = 1'b1;
    pb = pops.size();
    for (int i = 0; i < 4; i++) send_byte(rx_vec[i]);
    cycles(30);
    check("lb_pops", pops.size() - pb, 4);
    for (int i = 0; i < 4; i++) check("lb_data", {24'b0, pops[pb+i]}, {24'b0, rx_vec[i]});
    loopback = 1'b0;

    // Reset in the middle of a SEND write
    rx_ready = 1'b0;
    offer_byte(8'h5A);
    cycles(6);
    check("pre_rst_rxvalid", {31'b0, rx_valid}, 32'h1);
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_bus);
      if (bus_write) got = 1'b1;
    end
    check("mid_wr_reached", {31'b0, got}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("async_write",   {31'b0, bus_write}, 32'h0);
    check("async_txready", {31'b0, tx_ready},  32'h0);
    check("async_rxcount", {29'b0, rx_count},  32'h0);
    check("async_rxvalid", {31'b0, rx_valid},  32'h0);
    tx_valid = 1'b0;
    @(posedge clk_bus);
    #1 rst = 1'b0;
    @(negedge clk_bus);
    check("restart_idle_read", {31'b0, bus_read}, 32'h0);
    check("restart_idle_addr", {28'b0, bus_address}, 32'h0);
    @(negedge clk_bus);
    check("restart_poll_read", {31'b0, bus_read}, 32'h1);
    check("restart_poll_addr", {28'b0, bus_address}, 32'hC);
    rx_ready = 1'b1;
    cycles(10);

    check("txready_only_with_write", proto_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
